div_unit: RTL and testbench

Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the execute stage, directly upstream of the register file. It accepts operands and a destination index when idle and runs a radix-2 restoring division over 32 iterations. It then presents `rd`, `result` and a one-cycle `reg_write` strobe that connect straight to the regfile write port. The hazard logic uses `busy` to stall issue.

---
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Issue/writeback bundle between the execute stage and div_unit.
interface div_unit_if #(
    parameter int XLEN = 32
);
    // An op is accepted on a rising clk edge with start=1, busy=0 and flush=0.
    // result/rd are meaningful only while done=1; flush kills whatever is in flight.
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            reg_write;

    modport master (
        output start, op, rs1_val, rs2_val, rd_in, flush,
        input  busy, done, rd, result, reg_write
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_in, flush,
        output busy, done, rd, result, reg_write
    );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider, one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN short-cuts divide-by-zero and signed overflow.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0]      ITERS   = 6'd32;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_lat_q, rd_lat_d, rd_q, rd_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, result_q, result_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d, ovf_q, ovf_d;

    logic            accept, signed_op, in_div0, in_ovf, special;
    logic [XLEN-1:0] abs1, abs2, quo_fix, rem_fix;
    logic [XLEN:0]   shifted, trial;

    assign accept    = bus.start && !bus.flush && (state_q == S_IDLE || state_q == S_DONE);
    assign signed_op = !bus.op[0];
    assign abs1      = (signed_op && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
    assign abs2      = (signed_op && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;
    assign in_div0   = (bus.rs2_val == '0);
    assign in_ovf    = signed_op && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);

`ifdef DIV_FAST_SPECIAL_EN
    // Special cases enter CALC with a zero count: one pass-through cycle, then FIX.
    assign special = in_div0 || in_ovf;
`else
    assign special = 1'b0;
`endif

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // Divide-by-zero remainder falls out naturally: rem holds |rs1| and gets rs1's sign back.
    assign quo_fix = ovf_q     ? MIN_NEG :
                     div0_q    ? '1      :
                     neg_quo_q ? -quo_q  : quo_q;
    assign rem_fix = ovf_q     ? '0      :
                     neg_rem_q ? -rem_q  : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_lat_d  = rd_lat_q;
        rd_d      = rd_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d   = S_CALC;
                    cnt_d     = special ? 6'd0 : ITERS;
                    op_d      = bus.op;
                    rd_lat_d  = bus.rd_in;
                    quo_d     = abs1;
                    rem_d     = special ? abs1 : '0;
                    dvs_d     = abs2;
                    neg_quo_d = signed_op && (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
                    neg_rem_d = signed_op && bus.rs1_val[XLEN-1];
                    div0_d    = in_div0;
                    ovf_d     = in_ovf;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == 6'd0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                    if (!trial[XLEN]) begin
                        rem_d = trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                end
            end
            S_FIX: begin
                state_d  = S_DONE;
                result_d = op_q[1] ? rem_fix : quo_fix;
                rd_d     = rd_lat_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything, including a same-cycle start or a pending writeback.
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            rd_d     = rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_lat_q  <= '0;
            rd_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_lat_q  <= rd_lat_d;
            rd_q      <= rd_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done      = (state_q == S_DONE);
    assign bus.rd        = rd_q;
    assign bus.result    = result_q;
    assign bus.reg_write = bus.done && (rd_q != 5'd0);
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner sequences, random ops.
module tb_div_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    div_unit_if bus ();

    div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V semantics computed with 64-bit integer division.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
        end else begin
            sa = $signed({32'd0, a});
            sb = $signed({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
        return special ? 2 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Called away from an edge with the unit able to accept; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.op      = 2'($urandom);
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.rd_in   = 5'($urandom);
    endtask

    task automatic wait_done(input int first, output int lat);
        lat = first;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        exp_q.push_back(exp);
        issue(op, a, b, rd);
        check({name, " busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(0, lat);
        check({name, " latency"}, lat, exp_lat(op, a, b));
        check({name, " result"}, bus.result, exp_q.pop_front());
        check({name, " rd"}, {27'd0, bus.rd}, {27'd0, rd});
        check({name, " reg_write"}, {31'd0, bus.reg_write}, {31'd0, rd != 5'd0});
        @(posedge clk);
        #1;
        check({name, " done_width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd5,  32'd2};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIVU, 32'h0000_1234,  32'd0,          5'd8,  32'hFFFF_FFFF};
        vecs[5]  = '{OP_REM,  32'h0000_1234,  32'd0,          5'd8,  32'h0000_1234};
        vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000};
        vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0};
        vecs[8]  = '{OP_DIV,  32'hFFFF_FF00,  32'd0,          5'd31, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_REM,  32'hFFFF_FF00,  32'd0,          5'd1,  32'hFFFF_FF00};
        vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'hFFFF_FFFF};
        vecs[11] = '{OP_DIV,  32'd5,          32'hFFFF_FFFD,  5'd2,  32'hFFFF_FFFF};
        vecs[12] = '{OP_REM,  32'd5,          32'hFFFF_FFFD,  5'd2,  32'd2};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.rs1_val = 32'd0;
        bus.rs2_val = 32'd0;
        bus.rd_in   = 5'd0;
        bus.flush   = 1'b0;
        #22;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset reg_write", {31'd0, bus.reg_write}, 32'd0);
        check("reset rd", {27'd0, bus.rd}, 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

        // Flush mid-CALC, with a competing start in the same cycle.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd4);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush busy", {31'd0, bus.busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("flush no_done", {31'd0, seen}, 32'd0);
        run_op("after_flush", OP_DIVU, 32'd9, 32'd3, 5'd6, 32'd3);

        // Back-to-back: second op accepted in the DONE cycle, start pulses while busy ignored.
        exp_q.push_back(32'd10);
        issue(OP_DIVU, 32'd50, 32'd5, 5'd7);
        wait_done(0, lat);
        check("b2b first latency", lat, 34);
        check("b2b first result", bus.result, exp_q.pop_front());
        check("b2b first reg_write", {31'd0, bus.reg_write}, 32'd1);
        exp_q.push_back(ref_div(OP_REMU, 32'd50, 32'd7));
        issue(OP_REMU, 32'd50, 32'd7, 5'd0);
        check("b2b second busy", {31'd0, bus.busy}, 32'd1);
        check("b2b second done_drop", {31'd0, bus.done}, 32'd0);
        lat = 0;
        repeat (3) begin
            bus.start   = 1'b1;
            bus.rs1_val = $urandom;
            bus.rs2_val = $urandom_range(1, 9);
            bus.rd_in   = 5'd17;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        wait_done(lat, lat);
        check("b2b second latency", lat, 34);
        check("b2b second result", bus.result, exp_q.pop_front());
        check("b2b second rd", {27'd0, bus.rd}, 32'd0);
        check("b2b second reg_write", {31'd0, bus.reg_write}, 32'd0);
        @(posedge clk);
        #1;
        check("b2b no_queued", {31'd0, bus.busy}, 32'd0);

        // Async reset mid-CALC after a writeback left rd/result non-zero.
        run_op("pre_reset", OP_DIVU, 32'd77, 32'd7, 5'd12, 32'd11);
        issue(OP_DIVU, 32'd12345, 32'd7, 5'd9);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("areset busy", {31'd0, bus.busy}, 32'd0);
        check("areset done", {31'd0, bus.done}, 32'd0);
        check("areset reg_write", {31'd0, bus.reg_write}, 32'd0);
        check("areset rd", {27'd0, bus.rd}, 32'd0);
        check("areset result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("areset quiet", {31'd0, seen}, 32'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            rrd = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), rop, ra, rb, rrd, ref_div(rop, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
